// File: rtl/maze_move_probe_if.sv
// Move-request handshake and maze generator query bus for maze_move_probe.
// The master side is the button logic plus maze generator; the slave side is the probe.
interface maze_move_probe_if;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic [12:0] query_index;
    logic [15:0] query_data;
    logic [6:0]  pos_x;
    logic [5:0]  pos_y;
    logic        done;
    logic        blocked;

    modport master (
        output move_valid, move_dir, query_data,
        input  move_ready, query_index, pos_x, pos_y, done, blocked
    );

    modport slave (
        input  move_valid, move_dir, query_data,
        output move_ready, query_index, pos_x, pos_y, done, blocked
    );
endinterface

// File: rtl/maze_move_probe.sv
// Player movement arbiter: scans the sprite footprint at the target position through the
// maze generator and commits the move only when no scanned pixel is wall-coloured.
module maze_move_probe #(
    parameter int unsigned WIDTH  = 96,
    parameter int unsigned HEIGHT = 64,
    parameter int unsigned SPRITE = 9,
    parameter int unsigned X0     = 3,
    parameter int unsigned Y0     = 3,
    parameter logic [15:0] WALL   = 16'hFFFF
) (
    input logic              clk,
    input logic              rst_n,
    maze_move_probe_if.slave bus
);

    localparam int unsigned       CntW    = $clog2(SPRITE);
    localparam logic [CntW-1:0]   CntLast = CntW'(SPRITE - 1);
    localparam logic signed [7:0] MaxX    = 8'(WIDTH - SPRITE);
    localparam logic signed [7:0] MaxY    = 8'(HEIGHT - SPRITE);

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

    state_e          state_q, state_d;
    logic [6:0]      pos_x_q, pos_x_d;
    logic [5:0]      pos_y_q, pos_y_d;
    logic [6:0]      tx_q, tx_d;
    logic [5:0]      ty_q, ty_d;
    logic [CntW-1:0] cx_q, cx_d;
    logic [CntW-1:0] cy_q, cy_d;
    logic            hit_q, hit_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            done_q, done_d;
    logic            blocked_q, blocked_d;

    logic signed [7:0] tgt_x, tgt_y;
    logic              tgt_ok;
    logic              wall_hit;
    logic [12:0]       row, idx;

    // Target in 8-bit signed arithmetic so that a step off the top/left edge goes negative.
    always_comb begin
        tgt_x = $signed({1'b0, pos_x_q});
        tgt_y = $signed({2'b00, pos_y_q});
        unique case (bus.move_dir)
            2'd0: tgt_y = tgt_y - 8'sd1;
            2'd1: tgt_y = tgt_y + 8'sd1;
            2'd2: tgt_x = tgt_x - 8'sd1;
            2'd3: tgt_x = tgt_x + 8'sd1;
            default: ;
        endcase
        tgt_ok = !tgt_x[7] && !tgt_y[7] && (tgt_x <= MaxX) && (tgt_y <= MaxY);
    end

    assign wall_hit = rsp_valid_q && (bus.query_data == WALL);

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        hit_d       = hit_q | wall_hit;
        rsp_valid_d = (state_q == StScan);
        done_d      = 1'b0;
        blocked_d   = blocked_q;

        unique case (state_q)
            StIdle: begin
                if (bus.move_valid) begin
                    if (tgt_ok) begin
                        tx_d    = tgt_x[6:0];
                        ty_d    = tgt_y[5:0];
                        hit_d   = 1'b0;
                        cx_d    = '0;
                        cy_d    = '0;
                        state_d = StScan;
                    end else begin
                        done_d    = 1'b1;
                        blocked_d = 1'b1;
                    end
                end
            end
            StScan: begin
                if (cx_q == CntLast) begin
                    cx_d = '0;
                    if (cy_q == CntLast) begin
                        cy_d    = '0;
                        state_d = StDrain;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            StDrain: begin
                // hit_d already folds in the response to the last query.
                state_d   = StIdle;
                done_d    = 1'b1;
                blocked_d = hit_d;
                if (!hit_d) begin
                    pos_x_d = tx_q;
                    pos_y_d = ty_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        row = 13'(ty_q) + 13'(cy_q);
        idx = row * 13'(WIDTH) + 13'(tx_q) + 13'(cx_q);
    end

    assign bus.query_index = (state_q == StScan) ? idx : 13'd0;
    assign bus.move_ready  = (state_q == StIdle);
    assign bus.pos_x       = pos_x_q;
    assign bus.pos_y       = pos_y_q;
    assign bus.done        = done_q;
    assign bus.blocked     = blocked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pos_x_q     <= 7'(X0);
            pos_y_q     <= 6'(Y0);
            tx_q        <= '0;
            ty_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            hit_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            hit_q       <= hit_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            blocked_q   <= blocked_d;
        end
    end

endmodule

// File: tb/tb_maze_move_probe.sv
// Bench for maze_move_probe: a table of moves against a registered maze generator model,
// with a scoreboard of expected outcomes and hand-written edge and reset sequences.
module tb_maze_move_probe;

    logic clk = 1'b0;
    logic rst_n;

    maze_move_probe_if bus ();

    maze_move_probe dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] NONE = 13'h1FFF;

    logic [12:0] wall_idx = NONE;
    logic [15:0] wall_val = 16'hFFFF;

    // Generator: data registered one cycle after its index.
    always @(posedge clk) bus.query_data <= (bus.query_index == wall_idx) ? wall_val : 16'h0000;

    typedef struct {
        logic [1:0]  dir;
        logic [12:0] widx;
        logic [15:0] wval;
        bit          hold;
        bit          blk;
        int          x;
        int          y;
        int          lat;
    } vec_t;

    typedef struct {
        bit blk;
        int x;
        int y;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   n_vec = 0;
    int   n_err = 0;
    int   mx = 3;
    int   my = 3;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge; the accept happens on the next rising edge.
    task automatic run_move(input vec_t v);
        int   tx, ty, lat, bad_idx, bad_rdy, exp_idx, exp_rdy, k;
        exp_t e, g;
        tx = mx;
        ty = my;
        case (v.dir)
            2'd0:    ty--;
            2'd1:    ty++;
            2'd2:    tx--;
            default: tx++;
        endcase
        wall_idx       = v.widx;
        wall_val       = v.wval;
        bus.move_valid = 1'b1;
        bus.move_dir   = v.dir;
        e.blk = v.blk;
        e.x   = v.x;
        e.y   = v.y;
        sb.push_back(e);
        lat     = -1;
        bad_idx = 0;
        bad_rdy = 0;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            k       = c - 1;
            exp_idx = (v.lat > 1 && c <= 81) ? (ty + k / 9) * 96 + tx + k % 9 : 0;
            exp_rdy = (v.lat > 1 && c <= 82) ? 0 : 1;
            if (int'(bus.query_index) != exp_idx) bad_idx++;
            if (int'(bus.move_ready) != exp_rdy) bad_rdy++;
            if (bus.done) begin
                lat = c;
                break;
            end
            bus.move_valid = v.hold;
            bus.move_dir   = 2'(c);
        end
        if (!v.hold) bus.move_valid = 1'b0;
        check("latency", lat, v.lat);
        check("scan_index", bad_idx, 0);
        check("move_ready", bad_rdy, 0);
        if (lat > 0 && sb.size() > 0) begin
            g = sb.pop_front();
            check("blocked", int'(bus.blocked), int'(g.blk));
            check("pos_x", int'(bus.pos_x), g.x);
            check("pos_y", int'(bus.pos_y), g.y);
        end else begin
            sb.delete();
        end
        mx = v.x;
        my = v.y;
    endtask

    initial begin
        vec_t v;
        int   bad;

        tbl[0]  = '{2'd3, 13'd1068, 16'hFFFF, 1'b0, 1'b1, 3, 3, 83};
        tbl[1]  = '{2'd3, 13'd1068, 16'hFFFE, 1'b0, 1'b0, 4, 3, 83};
        tbl[2]  = '{2'd2, 13'd291,  16'hFFFF, 1'b0, 1'b1, 4, 3, 83};
        tbl[3]  = '{2'd0, NONE,     16'h0000, 1'b0, 1'b0, 4, 2, 83};
        tbl[4]  = '{2'd0, NONE,     16'h0000, 1'b0, 1'b0, 4, 1, 83};
        tbl[5]  = '{2'd0, NONE,     16'h0000, 1'b0, 1'b0, 4, 0, 83};
        tbl[6]  = '{2'd0, NONE,     16'h0000, 1'b0, 1'b1, 4, 0, 1};
        tbl[7]  = '{2'd1, 13'd484,  16'hFFFF, 1'b0, 1'b1, 4, 0, 83};
        tbl[8]  = '{2'd1, 13'd964,  16'hFFFF, 1'b0, 1'b0, 4, 1, 83};
        tbl[9]  = '{2'd2, NONE,     16'h0000, 1'b0, 1'b0, 3, 1, 83};
        tbl[10] = '{2'd1, NONE,     16'h0000, 1'b1, 1'b0, 3, 2, 83};
        tbl[11] = '{2'd1, NONE,     16'h0000, 1'b0, 1'b0, 3, 3, 83};

        rst_n          = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_pos_x", int'(bus.pos_x), 3);
        check("rst_pos_y", int'(bus.pos_y), 3);
        check("rst_ready", int'(bus.move_ready), 1);
        check("rst_done", int'(bus.done), 0);
        check("rst_blocked", int'(bus.blocked), 0);
        check("rst_index", int'(bus.query_index), 0);

        rst_n = 1'b1;
        bad   = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.pos_x != 7'd3 || bus.pos_y != 6'd3 || !bus.move_ready || bus.done
                || bus.query_index != 13'd0) bad++;
        end
        check("idle_stable", bad, 0);

        for (int i = 0; i < 12; i++) run_move(tbl[i]);

        // Walk to the right edge, then step past it.
        while (mx < 87) begin
            v = '{2'd3, NONE, 16'h0000, 1'b0, 1'b0, mx + 1, my, 83};
            run_move(v);
        end
        v = '{2'd3, NONE, 16'h0000, 1'b0, 1'b1, 87, 3, 1};
        run_move(v);
        v = '{2'd2, NONE, 16'h0000, 1'b0, 1'b0, 86, 3, 83};
        run_move(v);

        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) bad++;
        end
        check("done_single", bad, 0);

        // Reset in cycle 40 of a scan.
        bus.move_valid = 1'b1;
        bus.move_dir   = 2'd3;
        @(posedge clk);
        @(negedge clk);
        bus.move_valid = 1'b0;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", int'(bus.move_ready), 1);
        check("abort_pos_x", int'(bus.pos_x), 3);
        check("abort_pos_y", int'(bus.pos_y), 3);
        check("abort_index", int'(bus.query_index), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad   = 0;
        repeat (90) begin
            @(negedge clk);
            if (bus.done) bad++;
        end
        check("abort_no_done", bad, 0);
        mx = 3;
        my = 3;
        v  = '{2'd3, NONE, 16'h0000, 1'b0, 1'b0, 4, 3, 83};
        run_move(v);

        check("sb_leftover", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maze_move_probe.md
# maze_move_probe

Player-movement arbiter for the 96x64 OLED maze game. It reads the maze pixel generator through its `index` → `data` port and owns the player's top-left position. On each move request it scans the player's sprite footprint at the target position and commits the move only if no scanned pixel is wall-coloured. It sits between the debounced button logic and the maze pixel generator.

## Interface
- `WIDTH`, 96: screen width in pixels.
- `HEIGHT`, 64: screen height in pixels.
- `SPRITE`, 9: player square side in pixels.
- `X0`, 3: reset x position.
- `Y0`, 3: reset y position.
- `WALL`, 16'hFFFF: colour that counts as wall.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `move_valid`  in  1  move request, sampled only when `move_ready`=1.
- `move_dir`  in  2  0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1).
- `move_ready`  out  1  high exactly when in IDLE.
- `query_index`  out  13  pixel index y*WIDTH+x presented to the maze generator.
- `query_data`  in  16  generator colour, valid one cycle after its `query_index`.
- `pos_x`  out  7  player top-left x, registered.
- `pos_y`  out  6  player top-left y, registered.
- `done`  out  1  one-cycle pulse when a request finishes.
- `blocked`  out  1  valid with `done`: 1 means the move was rejected.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - Compute the target `(tx,ty)` as the current position ±1 per `move_dir`, in 8-bit signed arithmetic.
  - Legal range: tx in [0, WIDTH-SPRITE], ty in [0, HEIGHT-SPRITE].
  - On accept with target out of range: stay in IDLE, pulse `done`=1 and `blocked`=1 next cycle, issue no queries.
  - On accept with target in range: latch `(tx,ty)`, clear the `hit` flag, set cx=cy=0, go to SCAN.
- SCAN:
  - Each cycle drive `query_index` = (ty+cy)*WIDTH + (tx+cx).
  - Advance cx 0..SPRITE-1, then wrap cx to 0 and increment cy.
  - Exactly SPRITE*SPRITE queries are issued in row-major order. There is no early exit; latency is fixed.
  - After the query with cx=cy=SPRITE-1, go to DRAIN.
- Response pipeline:
  - A one-bit `rsp_valid` register is set on each SCAN cycle.
  - In any cycle with `rsp_valid`=1, `hit` |= (`query_data`==WALL).
  - The comparison is exact over 16 bits; e.g. 16'hFFFE is not a wall.
- DRAIN:
  - One cycle that samples the final response, then go to IDLE.
  - In the same edge: `done`<=1 and `blocked`<=final `hit`.
  - If the final `hit`=0, `pos` <= `(tx,ty)`; otherwise `pos` is unchanged.
- `move_valid` while not in IDLE is ignored, not queued.
- Outputs:
  - `query_index` is decoded from registered counters only; there is no combinational path from any input.
  - `query_index`=0 in IDLE and DRAIN.
  - Index width: max (HEIGHT-1)*WIDTH+WIDTH-1 = 6143 < 2^13.

## Timing
- Reset (async assert, sync release on the clock):
  - state=IDLE, `pos`=(X0,Y0).
  - `done`=0, `blocked`=0, `hit`=0, `rsp_valid`=0.
  - `move_ready`=1, `query_index`=0.
- Reset mid-scan aborts the request: no `done` pulse, and `pos` returns to (X0,Y0).
- Let cycle 0 be the accept cycle.
- In-range move:
  - SCAN occupies cycles 1..SPRITE², i.e. 1..81 for defaults.
  - DRAIN is cycle SPRITE²+1 = 82.
  - `done`, `blocked`, and the new `pos` are visible in cycle SPRITE²+2 = 83.
  - `move_ready` is 0 in cycles 1..82 and 1 again from cycle 83, so a back-to-back accept is allowed in cycle 83.
- Out-of-range move: `done`/`blocked`=1 in cycle 1, and `move_ready` stays 1 throughout.
- `done` is high for exactly one cycle per accepted request.
- Generator contract: the generator registers `data` on `clk` from `index`. The bench model is the same: data(t+1) = f(index(t)).

## Test plan
- Reset:
  - Assert `rst_n`=0 → `pos`=(3,3), `move_ready`=1, `done`=0, `query_index`=0.
  - Release and idle 10 cycles → no change.
- Open move right:
  - Bench model returns all-zero colours; `move_valid`=1, `move_dir`=3 in cycle 0.
  - Required: 81 queries; first `query_index`=292 (3*96+4), last =1068 (11*96+12).
  - Cycle 83: `done`=1, `blocked`=0, `pos`=(4,3).
- Wall on last pixel:
  - Same move; the model returns 16'hFFFF only for index 1068.
  - Cycle 83: `done`=1, `blocked`=1, `pos` stays (3,3). This proves DRAIN samples the final response.
  - Repeat with 16'hFFFE at index 1068 → `blocked`=0.
- Screen edge:
  - With all-zero model, issue up ×3 → `pos` y=0.
  - Fourth up → `done`=`blocked`=1 in cycle 1, zero queries issued, `pos`=(3,0).
  - Mirror the check at the right edge, where x=87 (WIDTH-SPRITE) is the maximum.
- Busy ignore:
  - Hold `move_valid`=1 with alternating dirs during cycles 1..82.
  - Required: exactly one `done` in cycle 83; the next accept happens in cycle 83.
- Reset mid-scan:
  - Drop `rst_n` in cycle 40 of a move.
  - Required: no `done`, `pos`=(3,3), `move_ready`=1 after release.
  - A following move completes normally in 83 cycles.
